// File: rtl/adder_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : adder_pkg
//  Purpose  : Shared constants and elaboration helpers for the pipelined
//             chunked adder/subtractor.
//  Revision : 1.0  initial release
// ============================================================================
package adder_pkg;

  localparam int N_DEFAULT = 32;
  localparam int S_DEFAULT = 4;
  localparam int W_DEFAULT = N_DEFAULT / S_DEFAULT;

  // Width of one pipeline chunk; guarded so a bad S cannot divide by zero
  // before the split check below reports the problem.
  function automatic int chunk_width(input int n, input int s);
    return (s > 0) ? (n / s) : n;
  endfunction

  // True when the operand width splits into S equal chunks.
  function automatic bit split_ok(input int n, input int s);
    return (s > 0) && ((n % s) == 0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/Ripple_Carry_Adder_Nbit.sv
`default_nettype none
// ============================================================================
//  Module   : Ripple_Carry_Adder_Nbit
//  Purpose  : Purely combinational N-bit ripple-carry adder used as the
//             per-stage chunk adder of the pipelined adder.
//  Revision : 1.0  initial release
// ============================================================================
module Ripple_Carry_Adder_Nbit
  import adder_pkg::*;
#(
  parameter int N = W_DEFAULT
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  logic         i_cin,
  output logic [N-1:0] o_sum,
  output logic         o_cout
);

  logic [N:0] w_c;

  assign w_c[0] = i_cin;

  // One full adder per bit; the carry ripples from bit 0 upward.
  for (genvar i = 0; i < N; i++) begin : g_bit
    assign o_sum[i]  = i_a[i] ^ i_b[i] ^ w_c[i];
    assign w_c[i+1]  = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
  end

  assign o_cout = w_c[N];

endmodule
`default_nettype wire

// File: rtl/pipelined_adder_nbit.sv
`default_nettype none
// ============================================================================
//  Module   : pipelined_adder_nbit
//  Purpose  : N-bit adder/subtractor split into S chunks, one chunk added per
//             pipeline stage with the inter-chunk carry registered. Valid/
//             ready handshake; the whole chain advances or holds as one.
//  Revision : 1.0  initial release
// ============================================================================
module pipelined_adder_nbit
  import adder_pkg::*;
#(
  parameter int N = N_DEFAULT,
  parameter int S = S_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic         cin,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] s,
  output logic         cout,
  output logic         ovf
);

  localparam int W = chunk_width(N, S);

  if (!split_ok(N, S)) begin : g_bad_split
    $error("pipelined_adder_nbit: N must be a non-zero multiple of S");
  end

  // The chain moves only when the output slot is empty or being drained.
  logic w_adv;
  assign w_adv    = ~out_valid | out_ready;
  assign in_ready = w_adv;

  for (genvar k = 0; k < S; k++) begin : g_stage
    // Operand bits still to be consumed when a beat enters this stage.
    localparam int REM = N - k * W;

    logic                 r_valid;
    logic [(k+1)*W-1:0]   r_sum;
    logic                 r_carry;
    logic                 r_sub;
    logic                 r_xsgn;
    logic                 r_ysgn;

    logic                 w_valid_in;
    logic [REM-1:0]       w_xop;
    logic [REM-1:0]       w_yop;
    logic                 w_cin;
    logic                 w_sub_in;
    logic                 w_xsgn_in;
    logic                 w_ysgn_in;
    logic [W-1:0]         w_chunk;
    logic                 w_cout;
    logic [(k+1)*W-1:0]   w_sum_next;

    if (k == 0) begin : g_head
      // y is inverted once here so later stages never look at sub again.
      assign w_valid_in = in_valid;
      assign w_xop      = x;
      assign w_yop      = sub ? ~y : y;
      assign w_cin      = sub | cin;
      assign w_sub_in   = sub;
      assign w_xsgn_in  = x[N-1];
      assign w_ysgn_in  = y[N-1];
      assign w_sum_next = w_chunk;
    end else begin : g_body
      assign w_valid_in = g_stage[k-1].r_valid;
      assign w_xop      = g_stage[k-1].g_fwd.r_x;
      assign w_yop      = g_stage[k-1].g_fwd.r_y;
      assign w_cin      = g_stage[k-1].r_carry;
      assign w_sub_in   = g_stage[k-1].r_sub;
      assign w_xsgn_in  = g_stage[k-1].r_xsgn;
      assign w_ysgn_in  = g_stage[k-1].r_ysgn;
      assign w_sum_next = {w_chunk, g_stage[k-1].r_sum};
    end

    Ripple_Carry_Adder_Nbit #(
      .N (W)
    ) u_chunk (
      .i_a    (w_xop[W-1:0]),
      .i_b    (w_yop[W-1:0]),
      .i_cin  (w_cin),
      .o_sum  (w_chunk),
      .o_cout (w_cout)
    );

    // Stage register: valid, completed low chunks, chunk carry, sign/sub tags.
    always_ff @(posedge clk) begin
      if (reset) begin
        r_valid <= 1'b0;
        r_sum   <= '0;
        r_carry <= 1'b0;
        r_sub   <= 1'b0;
        r_xsgn  <= 1'b0;
        r_ysgn  <= 1'b0;
      end else if (w_adv) begin
        r_valid <= w_valid_in;
        r_sum   <= w_sum_next;
        r_carry <= w_cout;
        r_sub   <= w_sub_in;
        r_xsgn  <= w_xsgn_in;
        r_ysgn  <= w_ysgn_in;
      end
    end

    if (k < S - 1) begin : g_fwd
      logic [REM-W-1:0] r_x;
      logic [REM-W-1:0] r_y;

      // Carry the not-yet-added high operand chunks to the next stage.
      always_ff @(posedge clk) begin
        if (reset) begin
          r_x <= '0;
          r_y <= '0;
        end else if (w_adv) begin
          r_x <= w_xop[REM-1:W];
          r_y <= w_yop[REM-1:W];
        end
      end
    end
  end

  assign out_valid = g_stage[S-1].r_valid;
  assign s         = g_stage[S-1].r_sum;
  assign cout      = g_stage[S-1].r_carry;
  // Signed overflow uses the effective (possibly inverted) sign of y.
  assign ovf       = (g_stage[S-1].r_xsgn ~^ (g_stage[S-1].r_ysgn ^ g_stage[S-1].r_sub))
                   & (s[N-1] ^ g_stage[S-1].r_xsgn);

endmodule
`default_nettype wire

// File: tb/tb_pipelined_adder_nbit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipelined_adder_nbit
//  Purpose  : Scoreboard bench for pipelined_adder_nbit (N = 32, S = 4).
//  Revision : 1.0  initial release
// ============================================================================
module tb_pipelined_adder_nbit;

  localparam int N   = 32;
  localparam int S   = 4;
  localparam int LAT = 4;

  typedef struct {
    logic [N-1:0] s;
    logic         c;
    logic         o;
    bit           chk_lat;
    int           acc_cyc;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] x = '0;
  logic [N-1:0] y = '0;
  logic         cin = 1'b0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [N-1:0] s;
  logic         cout;
  logic         ovf;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  pipelined_adder_nbit #(.N(N), .S(S)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .cout      (cout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference arithmetic for random beats: one wide add, no chunking.
  function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b,
                                 input logic ci, input logic sb);
    exp_t         e;
    logic [N-1:0] bp;
    logic [N:0]   t;
    bp = sb ? ~b : b;
    t  = {1'b0, a} + {1'b0, bp} + {{N{1'b0}}, (sb ? 1'b1 : ci)};
    e.s = t[N-1:0];
    e.c = t[N];
    e.o = (a[N-1] ~^ bp[N-1]) & (t[N-1] ^ a[N-1]);
    e.chk_lat = 1'b0;
    e.acc_cyc = 0;
    return e;
  endfunction

  // Present one beat, wait (bounded) for acceptance, record expectation.
  task automatic send(input logic [N-1:0] a, input logic [N-1:0] b,
                      input logic ci, input logic sb,
                      input logic [N-1:0] es, input logic ec, input logic eo,
                      input bit lat);
    exp_t e;
    int   w;
    x = a; y = b; cin = ci; sub = sb; in_valid = 1'b1;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1 within 50 cycles");
    end else begin
      e.s = es; e.c = ec; e.o = eo; e.chk_lat = lat; e.acc_cyc = cyc;
      q.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_rand(input bit lat);
    logic [N-1:0] a, b;
    logic         ci, sb;
    exp_t         e;
    a  = $urandom; b = $urandom;
    ci = 1'($urandom_range(0, 1));
    sb = 1'($urandom_range(0, 1));
    e  = model(a, b, ci, sb);
    send(a, b, ci, sb, e.s, e.c, e.o, lat);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1; in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1 reset = 1'b0;
    q.delete();
  endtask

  task automatic stall3();
    int w;
    w = 0;
    while (!out_valid && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    if (!out_valid) begin
      n_cmp++; n_bad++;
      $display("FAIL stall_wait: got out_valid=0 expected 1 within 50 cycles");
    end else begin
      out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1 out_ready = 1'b1;
    end
  endtask

  // Monitor: pops the scoreboard on every transfer and checks hold behaviour.
  logic [N-1:0] h_s;
  logic         h_c, h_o;
  bit           held_v = 1'b0;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        held_v = 1'b0;
      end else if (out_valid) begin
        if (held_v) chk("stall_hold", {s, cout, ovf}, {h_s, h_c, h_o});
        if (!out_ready) begin
          chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
          held_v = 1'b1; h_s = s; h_c = cout; h_o = ovf;
        end else begin
          held_v = 1'b0;
          if (q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_output: got s=%h with out_valid=1 expected no result", s);
          end else begin
            e = q.pop_front();
            chk("result", {s, cout, ovf}, {e.s, e.c, e.o});
            if (e.chk_lat) chk("latency", 64'(cyc - e.acc_cyc), 64'(LAT));
          end
        end
      end else begin
        held_v = 1'b0;
      end
    end
  end

  initial begin
    int w;
    // Reset then idle.
    do_reset(2);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle", {out_valid, s, cout, ovf, in_ready},
          {1'b0, 32'h0, 1'b0, 1'b0, 1'b1});
    end
    @(posedge clk); #1;

    // Single add with carry through every chunk.
    send(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    repeat (8) @(posedge clk);
    #1;

    // Directed subtract / overflow / boundary vectors, back to back.
    send(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b1);
    send(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b1);
    send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b1);
    send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1);
    send(32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0001_0000, 1'b0, 1'b0, 1'b1);
    send(32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    send(32'h0000_000A, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_0007, 1'b1, 1'b0, 1'b1);
    repeat (8) @(posedge clk);
    #1;

    // Back-to-back random stream.
    for (int i = 0; i < 100; i++) send_rand(1'b1);
    repeat (8) @(posedge clk);
    #1;

    // Backpressure: two 3-cycle stalls while a stream runs.
    fork
      begin
        for (int i = 0; i < 24; i++) send_rand(1'b0);
      end
      begin
        repeat (6) begin @(posedge clk); #1; end
        stall3();
        repeat (5) begin @(posedge clk); #1; end
        stall3();
      end
    join
    repeat (10) @(posedge clk);
    #1;

    // Reset mid-flight: three beats discarded, one fresh beat afterwards.
    send(32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0, 32'h3333_3333, 1'b0, 1'b0, 1'b1);
    send(32'h4444_4444, 32'h1111_1111, 1'b0, 1'b1, 32'h3333_3333, 1'b1, 1'b0, 1'b1);
    send(32'h0000_0001, 32'h0000_0001, 1'b1, 1'b0, 32'h0000_0003, 1'b0, 1'b0, 1'b1);
    do_reset(1);
    send(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 1'b0, 1'b0, 1'b1);
    repeat (12) @(posedge clk);

    // Drain check.
    w = 0;
    while (q.size() != 0 && w < 50) begin
      @(posedge clk);
      w++;
    end
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d results outstanding expected 0", q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipelined_adder_nbit.md
# pipelined_adder_nbit

Parametrised, pipelined N-bit adder/subtractor that splits the operands into S equal chunks, adds one chunk per pipeline stage and registers the inter-chunk carry between stages. Accepts one operation per cycle with a valid/ready handshake, supports downstream backpressure, and reports carry-out and signed overflow. It sits in the datapath wherever a wide add or subtract must close timing at a higher clock rate than a single ripple chain allows.

## Interface
- N, 32, operand/result width in bits
- S, 4, number of pipeline stages; N % S == 0, chunk width W = N/S; S = 1 is legal and gives a single registered stage
- clk  input  1  clock, rising edge
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  operand beat present
- in_ready  output  1  block accepts a beat this cycle
- x  input  N  operand A
- y  input  N  operand B
- cin  input  1  carry-in, used only when sub = 0
- sub  input  1  0: s = x + y + cin; 1: s = x − y, i.e. x + ~y + 1, with cin ignored
- out_valid  output  1  result beat present
- out_ready  input  1  downstream accepts the result
- s  output  N  sum or difference
- cout  output  1  carry out of bit N−1; for sub, 1 means no borrow
- ovf  output  1  two's-complement signed overflow

## Operation
- Single register chain of S stages. Each stage k holds:
  - a valid bit;
  - the completed low result chunks 0..k;
  - the carry out of chunk k;
  - the still-unused high operand chunks k+1..S−1, with y already inverted when sub = 1;
  - the sub flag.
- Stage k adds chunk k of x and y' plus the registered carry from stage k−1.
  - Stage 0 carry-in = sub ? 1 : cin.
- After the last chunk, the registers hold the full s and cout.
- ovf = (x[N−1] ~^ y'[N−1]) & (s[N−1] ^ x[N−1]), using the effective y' = sub ? ~y : y.
  - The operand sign bits travel with the last chunk.
- Advance enable: adv = ~out_valid | out_ready.
  - The whole chain shifts only when adv = 1; otherwise every stage holds.
  - in_ready = adv, combinational from out_valid and out_ready.
- A beat is accepted when in_valid & in_ready.
  - When adv = 1 and in_valid = 0, a bubble (valid = 0) enters stage 0.
- A result transfers when out_valid & out_ready.
  - s, cout and ovf stay stable while out_valid = 1 and out_ready = 0.
- Bubbles are not squeezed out. A stall freezes the entire pipe, including bubbles.

## Timing
- Latency: a beat accepted at edge t appears with out_valid = 1 after edge t+S−1, so S cycles from acceptance to a presentable result.
- Throughput: 1 beat per cycle while out_ready = 1.
- Reset:
  - all valid bits = 0;
  - out_valid = 0, s = 0, cout = 0, ovf = 0;
  - in_ready = 1 in the cycle after reset, because out_valid = 0.
- Reset mid-operation discards every in-flight beat. No result for those beats ever appears.
- Simultaneous acceptance and output transfer in one cycle is legal and required for full throughput.
- Stall with in_valid = 1: in_ready = 0, so the beat is not taken. The source holds x, y, cin, sub and in_valid.
- Wrap-around: carry out of bit N−1 goes to cout only. The s arithmetic is modulo 2^N.

## Structure
- Shared package, adder_pkg:
  - localparam-style constant for W derived from N/S;
  - elaboration check that N % S == 0.
- Sub-module: a W-bit combinational chunk adder, instantiated as Ripple_Carry_Adder_Nbit with N = W, once per stage inside a generate loop.
- Registers and handshake logic live in pipelined_adder_nbit only.

## Test plan
All scenarios use N = 32, S = 4.
- Reset, then idle:
  - Stimulus: hold reset 2 cycles, then keep in_valid = 0.
  - Response: out_valid = 0, s = 0, cout = 0, ovf = 0, in_ready = 1 for 10 cycles.
- Single add with full carry propagation:
  - Stimulus: x = 0xFFFF_FFFF, y = 0x0000_0000, cin = 1, sub = 0.
  - Response: exactly 4 cycles later, s = 0x0000_0000, cout = 1, ovf = 0; out_valid high for 1 cycle.
- Subtract and overflow:
  - Stimulus: x = 0x8000_0000, y = 0x0000_0001, sub = 1.
  - Response: s = 0x7FFF_FFFF, cout = 1, ovf = 1.
  - Then stimulus: x = 5, y = 7, sub = 1.
  - Response: s = 0xFFFF_FFFE, cout = 0, ovf = 0.
- Back-to-back stream:
  - Stimulus: 100 random beats on consecutive cycles, out_ready = 1.
  - Response: 100 results in order, matching a reference model, on consecutive cycles starting 4 cycles after the first acceptance.
- Backpressure:
  - Stimulus: stream random beats; drop out_ready for 3 cycles while out_valid = 1.
  - Response:
    - in_ready = 0 during the stall;
    - s, cout and ovf held constant;
    - no beat lost or duplicated;
    - order preserved after out_ready returns.
- Reset mid-flight:
  - Stimulus: accept 3 beats, then assert reset for 1 cycle.
  - Response: none of the 3 results ever asserts out_valid; a new beat accepted after reset returns correctly 4 cycles later.
